// File: rtl/delay_pkg.sv
// Shared types and defaults for the multi-channel delay timer.
package delay_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  localparam int DEF_CBITS  = 15;
  localparam int DEF_PERIOD = 25000;
endpackage

// File: rtl/delay_channel.sv
// One timer channel: IDLE/RUN FSM, tick counter, expiry pulse and
// sticky counter-bound violation flag.
module delay_channel
  import delay_pkg::*;
#(
  parameter int               CBITS      = DEF_CBITS,
  parameter logic [CBITS-1:0] RST_PERIOD = CBITS'(DEF_PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CBITS-1:0] period,
  output logic             pulse,   // next-cycle value of sig, for the shared any_sig register
  output logic             sig,
  output logic             busy,
  output logic             err
);

  ch_state_t        state, state_d;
  logic [CBITS-1:0] cnt, cnt_d;
  logic [CBITS-1:0] period_q, period_d;
  logic             mode_q, mode_d;

  // Next state: stop beats start, start beats expiry, counting only on ticks.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    period_d = period_q;
    mode_d   = mode_q;
    pulse    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d  = RUN;
      cnt_d    = '0;
      period_d = period;
      mode_d   = periodic;
    end else if (state == RUN && tick) begin
      if (cnt == period_q) begin
        pulse = 1'b1;
        cnt_d = '0;
        if (!mode_q) state_d = IDLE;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  // State and registered outputs; err latches any cnt > period_q observation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= RST_PERIOD;
      mode_q   <= 1'b0;
      sig      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      sig      <= pulse;
      err      <= err | (cnt > period_q);
    end
  end

  assign busy = (state == RUN);

endmodule

// File: rtl/delay_timer_multi.sv
// Multi-channel programmable delay/interval timer.
// Optional feature macro: DELAY_PRESCALE_EN -- when defined, running channels
// advance only once every PRESCALE clocks via a shared free-running prescaler.
module delay_timer_multi #(
  parameter int NUM_CH     = 4,
  parameter int CBITS      = delay_pkg::DEF_CBITS,
  parameter int DEF_PERIOD = delay_pkg::DEF_PERIOD,
  parameter int PRESCALE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CBITS-1:0] period,
  output logic [NUM_CH-1:0]       sig,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       err,
  output logic                    any_sig
);
  import delay_pkg::*;

  logic              tick;
  logic [NUM_CH-1:0] pulse;

`ifdef DELAY_PRESCALE_EN
  localparam int PBITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PBITS-1:0] pcnt;

  // Free-running divider; only rst realigns it, channel starts do not.
  always_ff @(posedge clk) begin
    if (rst)                              pcnt <= '0;
    else if (pcnt == PBITS'(PRESCALE-1))  pcnt <= '0;
    else                                  pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == PBITS'(PRESCALE-1));
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_channel #(
      .CBITS      (CBITS),
      .RST_PERIOD (CBITS'(DEF_PERIOD))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .start    (start[i]),
      .stop     (stop[i]),
      .periodic (periodic[i]),
      .period   (period[i*CBITS +: CBITS]),
      .pulse    (pulse[i]),
      .sig      (sig[i]),
      .busy     (busy[i]),
      .err      (err[i])
    );
  end

  // any_sig registered from the same next-cycle pulses so it aligns with sig.
  always_ff @(posedge clk) begin
    if (rst) any_sig <= 1'b0;
    else     any_sig <= |pulse;
  end

endmodule

// File: tb/tb_delay_timer_multi.sv
// Randomized + directed bench for delay_timer_multi with an arithmetic
// reference model and a queue-based scoreboard.
module tb_delay_timer_multi;
  localparam int NUM_CH = 4;
  localparam int CBITS  = 15;
`ifdef DELAY_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start, stop, periodic;
  logic [NUM_CH*CBITS-1:0] period;
  logic [NUM_CH-1:0]       sig, busy, err;
  logic                    any_sig;

  delay_timer_multi #(
    .NUM_CH(NUM_CH), .CBITS(CBITS), .DEF_PERIOD(25000), .PRESCALE(PS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .period(period), .sig(sig), .busy(busy), .err(err), .any_sig(any_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                e;
    logic [NUM_CH-1:0] sig;
    logic [NUM_CH-1:0] busy;
    logic              any;
  } exp_t;

  exp_t q[$];
  int   ecount = 0;
  int   total  = 0;
  int   bad    = 0;

  // reference model state: channel running, start edge, period, mode
  bit  m_run [NUM_CH];
  int  m_t0  [NUM_CH];
  int  m_p   [NUM_CH];
  bit  m_mode[NUM_CH];
  int  m_r = 0;
  int  cur_per[NUM_CH];

  always @(posedge clk) ecount++;

  // Monitor: compare whatever expectation belongs to the edge just taken.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0 && q[0].e < ecount) begin
      total++; bad++;
      $display("FAIL stale_expect edge=%0d now=%0d", q[0].e, ecount);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].e == ecount) begin
      x = q.pop_front();
      total++;
      if (sig !== x.sig) begin bad++; $display("FAIL sig edge=%0d got=%b want=%b", x.e, sig, x.sig); end
      total++;
      if (busy !== x.busy) begin bad++; $display("FAIL busy edge=%0d got=%b want=%b", x.e, busy, x.busy); end
      total++;
      if (any_sig !== x.any) begin bad++; $display("FAIL any_sig edge=%0d got=%b want=%b", x.e, any_sig, x.any); end
      total++;
      if (err !== '0) begin bad++; $display("FAIL err edge=%0d got=%b want=0", x.e, err); end
    end
  end

  // Drive one cycle of inputs, advance the model to the edge that samples
  // them and queue the expected outputs.
  task automatic step(input logic r, input logic [NUM_CH-1:0] st,
                      input logic [NUM_CH-1:0] sp, input logic [NUM_CH-1:0] pm);
    exp_t x;
    int   e, n;
    rst = r; start = st; stop = sp; periodic = pm;
    for (int i = 0; i < NUM_CH; i++) period[i*CBITS +: CBITS] = CBITS'(cur_per[i]);
    e = ecount + 1;
    x.e = e; x.sig = '0; x.busy = '0;
    if (r) m_r = e;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r || sp[i]) begin
        m_run[i] = 1'b0;
      end else if (st[i]) begin
        m_run[i] = 1'b1; m_t0[i] = e; m_p[i] = cur_per[i]; m_mode[i] = pm[i];
      end else if (m_run[i]) begin
        // ticks elapsed since start; expiry every (p+1)-th tick
        n = (e - m_r) / PS - (m_t0[i] - m_r) / PS;
        if ((e - m_r) % PS == 0 && n > 0 && n % (m_p[i] + 1) == 0) begin
          x.sig[i] = 1'b1;
          if (!m_mode[i]) m_run[i] = 1'b0;
        end
      end
      x.busy[i] = m_run[i];
    end
    x.any = |x.sig;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      cur_per[i] = 0; m_run[i] = 0; m_t0[i] = 0; m_p[i] = 0; m_mode[i] = 0;
    end
    // reset held three cycles
    for (int k = 0; k < 3; k++) step(1'b1, '0, '0, '0);
    idle(2);

    // ch0 periodic, period 4
    cur_per[0] = 4;
    step(1'b0, 4'b0001, '0, 4'b0001);
    cur_per[0] = 7;  // ignored while running
    idle(16);

    // ch1 one-shot, period 2
    cur_per[1] = 2;
    step(1'b0, 4'b0010, '0, 4'b0000);
    idle(6);

    // ch2 periodic, period 0; then stop+start together
    cur_per[2] = 0;
    step(1'b0, 4'b0100, '0, 4'b0100);
    idle(4);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100);
    idle(3);

    // ch3 period 10, restart when cnt reaches 9
    cur_per[3] = 10;
    step(1'b0, 4'b1000, '0, 4'b1000);
    idle(9);
    step(1'b0, 4'b1000, '0, 4'b1000);
    idle(14);
    // reset mid-run drops everything
    step(1'b1, '0, '0, '0);
    idle(3);

    // boundary: simultaneous expiry on all channels
    for (int i = 0; i < NUM_CH; i++) cur_per[i] = 3;
    step(1'b0, 4'b1111, '0, 4'b1111);
    idle(9);
    step(1'b0, '0, 4'b1111, '0);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [NUM_CH-1:0] st, sp, pm;
      logic r;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] = ($urandom_range(0, 19) == 0);
        sp[i] = ($urandom_range(0, 59) == 0);
        pm[i] = $urandom_range(0, 1) != 0;
        cur_per[i] = $urandom_range(0, 12);
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, st, sp, pm);
    end
    idle(2);

    // drain, bounded
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
